uart_tx_top: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_top.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_top.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmitter.
// The RX bench reuses even_par() for its reference model.
package uart_tx_pkg;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_CLKS_PER_TICK = 7;
  localparam int DEF_TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic even_par(input logic [DEF_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
// Pointers carry a wrap bit; full/empty flags are registered from the pointers.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full_now;
  logic              empty_now;
  logic              do_wr;
  logic              do_rd;

  // The flags lag the pointers by a cycle, so the raw pointer compare also
  // guards the write and read paths against a stale flag.
  assign full_now  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty_now = (wr_ptr == rd_ptr);
  assign do_wr     = wr_en && !full && !full_now;
  assign do_rd     = rd_en && !empty_now;
  assign dout      = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      full  <= full_now;
      empty <= empty_now;
    end
  end

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: FIFO-fed serialiser sending start, LSB-first data,
// optional even parity and stop, timed by a free-running baud tick.
module uart_tx_top
  import uart_tx_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int FIFO_DEPTH    = 16,
  parameter int CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int PARITY_EN     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d_in,
  output logic              tx,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_busy
);

  localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int BT_W   = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [BT_W-1:0]   btick_q, btick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic              bit_end;
  logic              last_bit;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  uart_tx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wr_en(wr_en),
    .rd_en(pop),
    .din  (d_in),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign tick     = (tick_cnt == TICK_W'(CLKS_PER_TICK - 1));
  assign bit_end  = (btick_q == BT_W'(TICKS_PER_BIT - 1));
  assign last_bit = (bit_q == BIT_W'(DATA_W - 1));

  assign tx       = tx_q;
  assign tx_full  = fifo_full;
  assign tx_empty = fifo_empty;
  assign tx_busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      btick_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      btick_q <= btick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level of the state being entered, so tx moves on the tick edge.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    btick_d = btick_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            par_d   = even_par(fifo_dout);
            btick_d = '0;
            bit_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            btick_d = '0;
            bit_d   = '0;
            state_d = DATA;
            tx_d    = shift_q[0];
          end else begin
            btick_d = btick_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            btick_d = '0;
            if (last_bit) begin
              if (PARITY_EN != 0) begin
                state_d = PARITY;
                tx_d    = par_q;
              end else begin
                state_d = STOP;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end else begin
            btick_d = btick_q + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            btick_d = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            btick_d = btick_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            btick_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_dout;
              par_d   = even_par(fifo_dout);
              bit_d   = '0;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            btick_d = btick_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top: parity and no-parity instances share clk/reset,
// and a line-sampling receiver model decodes each frame mid-bit.
module tb_uart_tx_top;
  import uart_tx_pkg::*;

  localparam int CLKS_PER_BIT = DEF_CLKS_PER_TICK * DEF_TICKS_PER_BIT;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stopb;
    int         start_cyc;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       wr_en_np = 1'b0;
  logic [7:0] d_in_np = 8'h00;
  logic       tx, tx_full, tx_empty, tx_busy;
  logic       tx_np, tx_full_np, tx_empty_np, tx_busy_np;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     reset_epoch = 0;
  frame_t rx_q[$];
  frame_t rx_np_q[$];

  uart_tx_top #(.PARITY_EN(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .d_in    (d_in),
    .tx      (tx),
    .tx_full (tx_full),
    .tx_empty(tx_empty),
    .tx_busy (tx_busy)
  );

  uart_tx_top #(.PARITY_EN(0)) dut_np (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_np),
    .d_in    (d_in_np),
    .tx      (tx_np),
    .tx_full (tx_full_np),
    .tx_empty(tx_empty_np),
    .tx_busy (tx_busy_np)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Receiver model: frames aborted by a reset are discarded.
  task automatic rxMonitor(input bit np);
    frame_t f;
    int     epoch;
    forever begin
      @(negedge clk);
      if (!reset && (np ? tx_np : tx) == 1'b0) begin
        epoch       = reset_epoch;
        f.start_cyc = cyc;
        f.data      = 8'h00;
        f.par       = 1'b0;
        repeat (CLKS_PER_BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS_PER_BIT) @(negedge clk);
          f.data[i] = np ? tx_np : tx;
        end
        if (!np) begin
          repeat (CLKS_PER_BIT) @(negedge clk);
          f.par = tx;
        end
        repeat (CLKS_PER_BIT) @(negedge clk);
        f.stopb = np ? tx_np : tx;
        if (epoch == reset_epoch && !reset) begin
          if (np) rx_np_q.push_back(f);
          else    rx_q.push_back(f);
        end
      end
    end
  endtask

  initial rxMonitor(1'b0);
  initial rxMonitor(1'b1);

  task automatic applyStimulus(input logic [7:0] b, input bit np, output int land_cyc);
    if (np) begin
      wr_en_np = 1'b1;
      d_in_np  = b;
    end else begin
      wr_en = 1'b1;
      d_in  = b;
    end
    @(negedge clk);
    wr_en    = 1'b0;
    wr_en_np = 1'b0;
    land_cyc = cyc;
  endtask

  function automatic frame_t getFrame(input bit np, input int idx);
    frame_t f;
    f.data      = 8'h00;
    f.par       = 1'b0;
    f.stopb     = 1'b0;
    f.start_cyc = -100000;
    if (np) begin
      if (idx < rx_np_q.size()) f = rx_np_q[idx];
    end else begin
      if (idx < rx_q.size()) f = rx_q[idx];
    end
    return f;
  endfunction

  task automatic waitFrames(input bit np, input int n, input int budget);
    int k = 0;
    while ((np ? rx_np_q.size() : rx_q.size()) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frame_count", np ? rx_np_q.size() : rx_q.size(), n);
  endtask

  task automatic waitBusyLow(input bit np, input int budget, output int fall_cyc);
    int k = 0;
    while ((np ? tx_busy_np : tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    fall_cyc = cyc;
    checkOutput("busy_timeout", np ? tx_busy_np : tx_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_t f;
    int     land, fall, lat, bad;

    repeat (3) @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_empty", tx_empty, 1'b1);
    checkOutput("rst_full", tx_full, 1'b0);
    checkOutput("rst_busy", tx_busy, 1'b0);
    reset = 1'b0;

    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b1 || tx_full !== 1'b0) bad++;
    end
    checkOutput("idle_500", bad, 0);

    // Single frame 0xA5: latency, content and exact frame length
    applyStimulus(8'hA5, 1'b0, land);
    checkOutput("empty_lag", tx_empty, 1'b1);
    @(negedge clk);
    checkOutput("empty_fall", tx_empty, 1'b0);
    waitFrames(1'b0, 1, 1500);
    f   = getFrame(1'b0, 0);
    lat = f.start_cyc - land;
    checkOutput("a5_latency", (lat >= 2 && lat <= 8), 1'b1);
    checkOutput("a5_data", f.data, 8'hA5);
    checkOutput("a5_parity", f.par, 1'b0);
    checkOutput("a5_stop", f.stopb, 1'b1);
    waitBusyLow(1'b0, 500, fall);
    checkOutput("a5_frame_len", fall - f.start_cyc, 1232);

    // 0x07: odd ones count gives parity 1; without parity the frame is 1120 clks
    rx_q.delete();
    applyStimulus(8'h07, 1'b0, land);
    waitFrames(1'b0, 1, 1500);
    f = getFrame(1'b0, 0);
    checkOutput("p07_data", f.data, 8'h07);
    checkOutput("p07_parity", f.par, 1'b1);
    waitBusyLow(1'b0, 500, fall);
    applyStimulus(8'h07, 1'b1, land);
    waitFrames(1'b1, 1, 1500);
    f = getFrame(1'b1, 0);
    checkOutput("np07_data", f.data, 8'h07);
    checkOutput("np07_stop", f.stopb, 1'b1);
    waitBusyLow(1'b1, 500, fall);
    checkOutput("np07_frame_len", fall - f.start_cyc, 1120);

    // Back-to-back frames: each start exactly one frame after the previous
    rx_q.delete();
    applyStimulus(8'h11, 1'b0, land);
    applyStimulus(8'h22, 1'b0, land);
    applyStimulus(8'h33, 1'b0, land);
    waitFrames(1'b0, 3, 4200);
    checkOutput("b2b_data0", getFrame(1'b0, 0).data, 8'h11);
    checkOutput("b2b_data1", getFrame(1'b0, 1).data, 8'h22);
    checkOutput("b2b_data2", getFrame(1'b0, 2).data, 8'h33);
    checkOutput("b2b_gap01", getFrame(1'b0, 1).start_cyc - getFrame(1'b0, 0).start_cyc, 1232);
    checkOutput("b2b_gap12", getFrame(1'b0, 2).start_cyc - getFrame(1'b0, 1).start_cyc, 1232);
    waitBusyLow(1'b0, 500, fall);

    // Fill to full, then a dropped write of 0xFF
    rx_q.delete();
    for (int i = 0; i < 17; i++) applyStimulus(8'(i), 1'b0, land);
    @(negedge clk);
    checkOutput("full_set", tx_full, 1'b1);
    applyStimulus(8'hFF, 1'b0, land);
    checkOutput("full_hold", tx_full, 1'b1);
    waitFrames(1'b0, 17, 17 * 1232 + 600);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (getFrame(1'b0, i).data !== 8'(i)) bad++;
    end
    checkOutput("full_stream_order", bad, 0);
    repeat (3000) @(negedge clk);
    checkOutput("full_no_ff_frame", rx_q.size(), 17);
    checkOutput("full_cleared", tx_full, 1'b0);

    // Reset in the middle of DATA with two bytes queued
    rx_q.delete();
    applyStimulus(8'h5A, 1'b0, land);
    applyStimulus(8'h3C, 1'b0, land);
    applyStimulus(8'h99, 1'b0, land);
    bad = 0;
    while (tx === 1'b1 && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    checkOutput("rst_frame_started", tx, 1'b0);
    repeat (CLKS_PER_BIT * 5) @(negedge clk);
    checkOutput("rst_in_data", tx_busy, 1'b1);
    reset_epoch++;
    reset = 1'b1;
    #1;
    checkOutput("midrst_tx", tx, 1'b1);
    checkOutput("midrst_empty", tx_empty, 1'b1);
    checkOutput("midrst_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checkOutput("postrst_quiet", bad, 0);
    checkOutput("postrst_no_frames", rx_q.size(), 0);
    checkOutput("postrst_empty", tx_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
